// File: rtl/ocx_leaf_pkg.sv
// ocx_leaf_pkg: shared sizing helpers for the ocx_leaf blocks
package ocx_leaf_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic bit widths_ok(input int depth, input int aw, input int cw);
    return (aw == clog2(depth)) && (cw == clog2(depth + 2));
  endfunction
endpackage

// File: rtl/ocx_leaf_inferd_regfile_1clk.sv
// ocx_leaf_inferd_regfile_1clk: single-clock distributed-RAM regfile, one write port, async read
module ocx_leaf_inferd_regfile_1clk #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 576,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ocx_leaf_inferd_regfile_fifo.sv
// ocx_leaf_inferd_regfile_fifo: FWFT FIFO over an inferred regfile with a registered head stage
module ocx_leaf_inferd_regfile_fifo
  import ocx_leaf_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_WIDTH = 576,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH = 5,
  parameter int AF_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [FIFO_WIDTH-1:0] rd_data,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output logic                  almost_full
);
  if (!widths_ok(FIFO_DEPTH, ADDR_WIDTH, CNT_WIDTH) || FIFO_DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH + 1) begin : g_bad_params
    $error("ocx_leaf_inferd_regfile_fifo: inconsistent FIFO_DEPTH/ADDR_WIDTH/CNT_WIDTH/AF_LEVEL");
  end
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]  mem_count, mem_count_n, occ_n;
  logic [FIFO_WIDTH-1:0] ram_rdata;
  logic                  push, pop, load, rd_valid_n;
  function automatic logic [ADDR_WIDTH-1:0] inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
  endfunction
  assign wr_ready = mem_count != CNT_WIDTH'(FIFO_DEPTH);
  assign push = wr_valid && wr_ready;
  assign pop  = rd_valid && rd_ready;
  // head register refills whenever it is empty or being consumed
  assign load = (mem_count != '0) && (!rd_valid || pop);
  always_comb begin
    mem_count_n = mem_count + CNT_WIDTH'(push) - CNT_WIDTH'(load);
    rd_valid_n  = load || (rd_valid && !pop);
    occ_n       = mem_count_n + CNT_WIDTH'(rd_valid_n);
  end
  ocx_leaf_inferd_regfile_1clk #(.DEPTH(FIFO_DEPTH), .WIDTH(FIFO_WIDTH), .AW(ADDR_WIDTH)) u_rf (
    .clk(clk), .we(push), .waddr(wr_ptr), .wdata(wr_data), .raddr(rd_ptr), .rdata(ram_rdata)
  );
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_count   <= '0;
      rd_valid    <= 1'b0;
      occupancy   <= '0;
      almost_full <= 1'b0;
      if (rst) rd_data <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (load) begin
        rd_ptr  <= inc(rd_ptr);
        rd_data <= ram_rdata;
      end
      mem_count   <= mem_count_n;
      rd_valid    <= rd_valid_n;
      occupancy   <= occ_n;
      almost_full <= occ_n >= CNT_WIDTH'(AF_LEVEL);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !wr_ready));
      assert (mem_count <= CNT_WIDTH'(FIFO_DEPTH));
      assert (occupancy == mem_count + CNT_WIDTH'(rd_valid));
    end
  end
endmodule

// File: tb/tb_ocx_leaf_inferd_regfile_fifo.sv
// tb_ocx_leaf_inferd_regfile_fifo: directed checks on a depth-16 FIFO plus a depth-5 wrap run
module tb_ocx_leaf_inferd_regfile_fifo;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic         a_flush = 0, a_wr_valid = 0, a_wr_ready, a_rd_valid, a_rd_ready = 0, a_almost_full;
  logic [575:0] a_wr_data = '0, a_rd_data;
  logic [4:0]   a_occupancy;
  logic         b_flush = 0, b_wr_valid = 0, b_wr_ready, b_rd_valid, b_rd_ready = 0, b_almost_full;
  logic [15:0]  b_wr_data = '0, b_rd_data;
  logic [2:0]   b_occupancy;
  int checks = 0, errors = 0;

  ocx_leaf_inferd_regfile_fifo dut (
    .clk(clk), .rst(rst), .flush(a_flush), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready),
    .wr_data(a_wr_data), .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_data(a_rd_data),
    .occupancy(a_occupancy), .almost_full(a_almost_full)
  );
  ocx_leaf_inferd_regfile_fifo #(.FIFO_DEPTH(5), .FIFO_WIDTH(16), .ADDR_WIDTH(3), .CNT_WIDTH(3), .AF_LEVEL(4)) dut5 (
    .clk(clk), .rst(rst), .flush(b_flush), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .wr_data(b_wr_data), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data),
    .occupancy(b_occupancy), .almost_full(b_almost_full)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) step();
    rst = 0;
    step();
    checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b want 0", a_rd_valid); end
    checks++; if (a_rd_data !== 576'd0) begin errors++; $display("FAIL reset_rd_data: got %0h want 0", a_rd_data); end
    checks++; if (a_occupancy !== 5'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", a_occupancy); end
    checks++; if (a_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %0b want 1", a_wr_ready); end
    checks++; if (a_almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %0b want 0", a_almost_full); end
    checks++; if (b_occupancy !== 3'd0 || b_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_d5: got occ %0d rv %0b want 0 0", b_occupancy, b_rd_valid); end
  endtask

  task automatic test_single_word;
    a_wr_valid = 1; a_wr_data = 576'hA5;
    step();
    a_wr_valid = 0;
    checks++; if (a_rd_valid !== 1'b0 || a_occupancy !== 5'd1) begin errors++; $display("FAIL single_latency: got rv %0b occ %0d want 0 1", a_rd_valid, a_occupancy); end
    step();
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 576'hA5) begin errors++; $display("FAIL single_head: got rv %0b data %0h want 1 a5", a_rd_valid, a_rd_data); end
    checks++; if (a_occupancy !== 5'd1) begin errors++; $display("FAIL single_occ: got %0d want 1", a_occupancy); end
    a_rd_ready = 1;
    step();
    a_rd_ready = 0;
    checks++; if (a_rd_valid !== 1'b0 || a_occupancy !== 5'd0) begin errors++; $display("FAIL single_pop: got rv %0b occ %0d want 0 0", a_rd_valid, a_occupancy); end
  endtask

  task automatic test_fill_drain;
    int accepted = 0;
    int af_occ = 0;
    for (int i = 0; i <= 20; i++) begin
      a_wr_valid = 1; a_wr_data = 576'(i);
      if (a_wr_ready) accepted++;
      step();
      if (a_almost_full && af_occ == 0) af_occ = a_occupancy;
    end
    a_wr_valid = 0;
    checks++; if (accepted != 17) begin errors++; $display("FAIL fill_accepted: got %0d want 17", accepted); end
    checks++; if (a_wr_ready !== 1'b0) begin errors++; $display("FAIL fill_wr_ready: got %0b want 0", a_wr_ready); end
    checks++; if (a_occupancy !== 5'd17) begin errors++; $display("FAIL fill_occ: got %0d want 17", a_occupancy); end
    checks++; if (af_occ != 12) begin errors++; $display("FAIL fill_af_first: got %0d want 12", af_occ); end
    a_rd_ready = 1;
    for (int j = 0; j <= 16; j++) begin
      checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 576'(j)) begin errors++; $display("FAIL drain_word%0d: got rv %0b data %0h want 1 %0h", j, a_rd_valid, a_rd_data, j); end
      step();
    end
    a_rd_ready = 0;
    checks++; if (a_occupancy !== 5'd0 || a_rd_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got occ %0d rv %0b want 0 0", a_occupancy, a_rd_valid); end
  endtask

  task automatic test_full_pop_push;
    for (int i = 0; i < 17; i++) begin
      a_wr_valid = 1; a_wr_data = 576'(100 + i);
      step();
    end
    checks++; if (a_occupancy !== 5'd17 || a_wr_ready !== 1'b0) begin errors++; $display("FAIL full_setup: got occ %0d wr_ready %0b want 17 0", a_occupancy, a_wr_ready); end
    a_wr_data = 576'h99; a_rd_ready = 1;
    step();
    a_rd_ready = 0;
    checks++; if (a_occupancy !== 5'd16) begin errors++; $display("FAIL full_pop_occ: got %0d want 16", a_occupancy); end
    checks++; if (a_wr_ready !== 1'b1) begin errors++; $display("FAIL full_pop_wr_ready: got %0b want 1", a_wr_ready); end
    a_wr_data = 576'h77;
    step();
    a_wr_valid = 0;
    checks++; if (a_occupancy !== 5'd17) begin errors++; $display("FAIL full_repush_occ: got %0d want 17", a_occupancy); end
    a_rd_ready = 1;
    for (int j = 1; j <= 17; j++) begin
      logic [575:0] exp;
      exp = (j == 17) ? 576'h77 : 576'(100 + j);
      checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== exp) begin errors++; $display("FAIL full_drain%0d: got rv %0b data %0h want 1 %0h", j, a_rd_valid, a_rd_data, exp); end
      step();
    end
    a_rd_ready = 0;
  endtask

  task automatic test_flush;
    for (int i = 0; i < 9; i++) begin
      a_wr_valid = 1; a_wr_data = 576'(200 + i);
      step();
    end
    checks++; if (a_occupancy !== 5'd9 || a_rd_data !== 576'd200) begin errors++; $display("FAIL flush_setup: got occ %0d data %0h want 9 c8", a_occupancy, a_rd_data); end
    a_flush = 1; a_wr_data = 576'hEE; a_rd_ready = 1;
    step();
    a_flush = 0; a_rd_ready = 0;
    checks++; if (a_occupancy !== 5'd0 || a_rd_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got occ %0d rv %0b want 0 0", a_occupancy, a_rd_valid); end
    checks++; if (a_rd_data !== 576'd200) begin errors++; $display("FAIL flush_hold_data: got %0h want c8", a_rd_data); end
    checks++; if (a_wr_ready !== 1'b1 || a_almost_full !== 1'b0) begin errors++; $display("FAIL flush_flags: got wr_ready %0b af %0b want 1 0", a_wr_ready, a_almost_full); end
    a_wr_data = 576'h3C;
    step();
    a_wr_valid = 0;
    step();
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 576'h3C || a_occupancy !== 5'd1) begin errors++; $display("FAIL flush_next_word: got rv %0b data %0h occ %0d want 1 3c 1", a_rd_valid, a_rd_data, a_occupancy); end
    a_rd_ready = 1;
    step();
    a_rd_ready = 0;
  endtask

  task automatic test_wrap_depth5;
    int q[$];
    int n = 0;
    for (int c = 0; c < 100; c++) begin
      b_wr_valid = 1'($urandom_range(0, 1));
      b_rd_ready = 1'($urandom_range(0, 1));
      b_wr_data = 16'(n);
      if (b_rd_valid && b_rd_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL wrap_pop_empty_model: got %0h want none", b_rd_data); end
        else begin
          if (b_rd_data !== 16'(q[0])) begin errors++; $display("FAIL wrap_order: got %0h want %0h", b_rd_data, q[0]); end
          void'(q.pop_front());
        end
      end
      if (b_wr_valid && b_wr_ready) begin q.push_back(n); n++; end
      step();
      checks++; if (b_occupancy !== 3'(q.size())) begin errors++; $display("FAIL wrap_occ: got %0d want %0d", b_occupancy, q.size()); end
      checks++; if (b_almost_full !== (q.size() >= 4)) begin errors++; $display("FAIL wrap_af: got %0b want %0b", b_almost_full, q.size() >= 4); end
      checks++; if (dut5.wr_ptr > 3'd4 || dut5.rd_ptr > 3'd4) begin errors++; $display("FAIL wrap_ptr: got wr %0d rd %0d want <=4", dut5.wr_ptr, dut5.rd_ptr); end
    end
    b_wr_valid = 0; b_rd_ready = 0;
    checks++; if (n < 10) begin errors++; $display("FAIL wrap_traffic: got %0d pushes want >=10", n); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill_drain();
    test_full_pop_push();
    test_flush();
    test_wrap_depth5();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
